// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side burst controller.
package fifo_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} burst_rd_state_e;
endpackage

// File: rtl/stream_out_reg.sv
// One-deep valid/ready output register; a load always wins over draining the held word.
module stream_out_reg #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload
);
    // The top bit carries the last flag and is cleared once the word is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_payload <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid            <= 1'b0;
            out_payload[WIDTH-1] <= 1'b0;
        end
    end
endmodule

// File: rtl/sync_fifo_1w1r.sv
// Single-clock FIFO, one write port and one first-word-fall-through read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_1w1r #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          valid,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a requested number of words from a FWFT FIFO and streams them out with a last flag.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    input  logic [LEN_W-1:0]      req_len,
    output logic                  req_ready,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    burst_rd_state_e        state;
    burst_rd_state_e        next_state;
    logic [LEN_W-1:0]       remaining;
    logic [DATA_WIDTH:0]    out_payload;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    next_state = (req_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Pop only when the output register is empty or being emptied this cycle.
                fifo_pop = fifo_valid && (remaining != '0) && (!out_valid || out_ready);
                if (fifo_pop && (remaining == LEN_W'(1))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            remaining <= '0;
        end else if ((state == IDLE) && req_valid) begin
            remaining <= req_len;
        end else if (fifo_pop) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    stream_out_reg #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_reg (
        .clk         (clk),
        .rstn        (rstn),
        .load        (fifo_pop),
        .load_data   ({(remaining == LEN_W'(1)), fifo_rd_data}),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_payload (out_payload)
    );

    assign out_last = out_payload[DATA_WIDTH];
    assign out_data = out_payload[DATA_WIDTH-1:0];

    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rstn)
        !(fifo_pop && !fifo_valid));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_last)));
    a_done_pulse: assert property (@(posedge clk) disable iff (!rstn)
        done |=> !done);
    // Reaching DRAIN with a zero count means exactly req_len words were popped.
    a_all_popped: assert property (@(posedge clk) disable iff (!rstn)
        (state == DRAIN) |-> (remaining == '0));
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: sync_fifo_1w1r feeding fifo_burst_reader, with a negedge stream monitor.
module tb_fifo_burst_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          push;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_valid;
    logic [3:0]    fifo_count;
    logic          req_valid;
    logic [LW-1:0] req_len;
    logic          req_ready;
    logic          fifo_pop;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    int            ncyc = 0;
    int            req_cyc, ready_cyc, first_pop, first_valid, last_cyc, done_cyc;
    int            pops, bad_pops, valid_seen, done_cnt, stall_err, full_after;
    bit            req_seen, prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] got_data[$];
    bit            got_last[$];

    always #5 clk = ~clk;

    sync_fifo_1w1r #(.DATA_WIDTH(DW), .DEPTH(8)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .wr_data (wr_data),
        .full    (full),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .fifo_valid   (fifo_valid),
        .fifo_rd_data (fifo_rd_data),
        .fifo_pop     (fifo_pop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    // Inputs change just after posedge, so the negedge view equals what the next posedge samples.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (req_valid && req_ready) begin
                    req_cyc  = ncyc;
                    req_seen = 1'b1;
                end else if (req_seen && req_ready && ready_cyc < 0) begin
                    ready_cyc = ncyc;
                end
                if (first_pop >= 0 && ncyc == first_pop + 1) full_after = int'(full);
                if (fifo_pop) begin
                    pops++;
                    if (!fifo_valid) bad_pops++;
                    if (first_pop < 0) first_pop = ncyc;
                end
                if (out_valid) begin
                    valid_seen++;
                    if (first_valid < 0) first_valid = ncyc;
                end
                if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) stall_err++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    if (out_last) last_cyc = ncyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = ncyc;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clear_log();
        req_cyc = -1; ready_cyc = -1; first_pop = -1; first_valid = -1;
        last_cyc = -1; done_cyc = -1; full_after = -1;
        pops = 0; bad_pops = 0; valid_seen = 0; done_cnt = 0; stall_err = 0;
        req_seen = 1'b0; prev_stall = 1'b0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push    = 1'b1;
            wr_data = base + DW'(i);
            step();
        end
        push = 1'b0;
    endtask

    task automatic applyStimulus(input logic [LW-1:0] len);
        req_valid = 1'b1;
        req_len   = len;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        step();
        step();
        checkOutput({tag, "_done_count"}, done_cnt, 1);
    endtask

    task automatic check_burst(input string tag, input logic [DW-1:0] base, input int n);
        logic [DW-1:0] d;
        bit            l;
        checkOutput({tag, "_words"}, got_data.size(), n);
        for (int i = 0; i < n; i++) begin
            d = (i < got_data.size()) ? got_data[i] : '1;
            l = (i < got_last.size()) ? got_last[i] : 1'b0;
            checkOutput($sformatf("%s_data%0d", tag, i), d, base + DW'(i));
            checkOutput($sformatf("%s_last%0d", tag, i), l, (i == n - 1));
        end
        checkOutput({tag, "_pops"}, pops, n);
        checkOutput({tag, "_empty_pops"}, bad_pops, 0);
    endtask

    initial begin
        logic [5:0] ready_pat;
        ready_pat = 6'b101001;
        rstn = 1'b0; push = 1'b0; wr_data = '0;
        req_valid = 1'b0; req_len = '0; out_ready = 1'b1;
        clear_log();
        step();
        step();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pop", fifo_pop, 0);
        checkOutput("rst_busy", busy, 0);
        rstn = 1'b1;
        step();
        checkOutput("rst_req_ready", req_ready, 1);

        // Basic four-word burst at full rate
        push_words(32'hA0, 4);
        checkOutput("t1_fifo_count", fifo_count, 4);
        clear_log();
        applyStimulus(8'd4);
        wait_done("t1", 40);
        check_burst("t1", 32'hA0, 4);
        checkOutput("t1_first_pop", first_pop, req_cyc + 1);
        checkOutput("t1_first_valid", first_valid, req_cyc + 2);
        checkOutput("t1_back_to_back", last_cyc, first_valid + 3);
        checkOutput("t1_done_cyc", done_cyc, last_cyc + 1);
        checkOutput("t1_ready_cyc", ready_cyc, last_cyc + 2);
        checkOutput("t1_fifo_empty", fifo_valid, 0);

        // Zero-length request
        clear_log();
        applyStimulus(8'd0);
        wait_done("t2", 10);
        checkOutput("t2_done_cyc", done_cyc, req_cyc + 1);
        checkOutput("t2_ready_cyc", ready_cyc, req_cyc + 2);
        checkOutput("t2_pops", pops, 0);
        checkOutput("t2_valid_seen", valid_seen, 0);

        // FIFO runs dry mid-burst, then refills
        push_words(32'hB0, 2);
        clear_log();
        applyStimulus(8'd5);
        repeat (10) step();
        checkOutput("t3_mid_pops", pops, 2);
        checkOutput("t3_mid_fifo_valid", fifo_valid, 0);
        checkOutput("t3_mid_pop", fifo_pop, 0);
        checkOutput("t3_mid_out_valid", out_valid, 0);
        checkOutput("t3_mid_busy", busy, 1);
        push_words(32'hB2, 3);
        wait_done("t3", 40);
        check_burst("t3", 32'hB0, 5);

        // Downstream backpressure
        push_words(32'hC0, 3);
        clear_log();
        out_ready = ready_pat[0];
        applyStimulus(8'd3);
        for (int i = 1; i < 6; i++) begin
            out_ready = ready_pat[i];
            step();
        end
        out_ready = 1'b1;
        wait_done("t4", 40);
        check_burst("t4", 32'hC0, 3);
        checkOutput("t4_stall_stable", stall_err, 0);

        // Maximum-fill burst from a full FIFO
        push_words(32'hD0, 8);
        checkOutput("t5_full_before", full, 1);
        clear_log();
        applyStimulus(8'd8);
        wait_done("t5", 60);
        check_burst("t5", 32'hD0, 8);
        checkOutput("t5_back_to_back", last_cyc, first_valid + 7);
        checkOutput("t5_full_after_pop", full_after, 0);

        // Reset in the middle of a burst abandons it
        push_words(32'hE0, 6);
        clear_log();
        applyStimulus(8'd6);
        for (int i = 0; i < 50 && got_data.size() < 2; i++) step();
        checkOutput("t6_words_before_reset", got_data.size(), 2);
        rstn = 1'b0;
        step();
        step();
        checkOutput("t6_out_valid", out_valid, 0);
        checkOutput("t6_out_last", out_last, 0);
        checkOutput("t6_out_data", out_data, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_pop", fifo_pop, 0);
        rstn = 1'b1;
        repeat (3) step();
        checkOutput("t6_no_done", done_cnt, 0);
        checkOutput("t6_req_ready", req_ready, 1);
        push_words(32'hF0, 2);
        clear_log();
        applyStimulus(8'd2);
        wait_done("t6b", 40);
        check_burst("t6b", 32'hF0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
